// File: rtl/sevenseg_scan_mux.sv
// Four-digit common-anode 7-segment scan multiplexer. Inputs are snapshotted once
// per frame and then displayed one digit per refresh slot, with blanking, DP and blink.
module sevenseg_scan_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_en,
  input  logic       blank_lz,
  input  logic       blink,
  input  logic       en,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  logic [TW-1:0] tick_cnt_r;
  logic [1:0]    sel_r;
  logic          tick_s;
  logic          frame_end_s;

  logic          init_r;
  logic [3:0]    d3_r, d2_r, d1_r, d0_r;
  logic [3:0]    dp_en_r;
  logic          blank_lz_r;

  logic [FW-1:0] frame_cnt_r;
  logic          phase_r;

  logic [3:0]    digit_s;
  logic          b3_s, b2_s, b1_s;
  logic          blanked_s;
  logic          dark_s;
  logic [3:0]    an_nxt_s;
  logic [6:0]    seg_nxt_s;
  logic          dp_nxt_s;

  assign tick_s      = (tick_cnt_r == TICK_LAST);
  assign frame_end_s = tick_s && (sel_r == 2'd3);

  // Refresh prescaler and digit select.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_r <= '0;
      sel_r      <= 2'd0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      sel_r      <= sel_r + 2'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Frame snapshot; the init flag forces a capture on the first clock after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_r     <= 1'b0;
      d3_r       <= 4'd0;
      d2_r       <= 4'd0;
      d1_r       <= 4'd0;
      d0_r       <= 4'd0;
      dp_en_r    <= 4'd0;
      blank_lz_r <= 1'b0;
    end else if (!init_r || frame_end_s) begin
      init_r     <= 1'b1;
      d3_r       <= d3;
      d2_r       <= d2;
      d1_r       <= d1;
      d0_r       <= d0;
      dp_en_r    <= dp_en;
      blank_lz_r <= blank_lz;
    end
  end

  // Blink frame counter and phase, held clear while blink is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (!blink) begin
      frame_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (frame_end_s) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + FW'(1);
      end
    end
  end

  // Digit decode, blanking and darkening for the selected slot.
  always_comb begin
    digit_s   = 4'd0;
    blanked_s = 1'b0;
    an_nxt_s  = 4'b1111;
    seg_nxt_s = 7'b1111111;
    dp_nxt_s  = 1'b1;

    b3_s = blank_lz_r && (d3_r == 4'd0) && !dp_en_r[3];
    b2_s = b3_s && (d2_r == 4'd0) && !dp_en_r[2];
    b1_s = b2_s && (d1_r == 4'd0) && !dp_en_r[1];

    case (sel_r)
      2'd0: begin digit_s = d0_r; blanked_s = 1'b0; end
      2'd1: begin digit_s = d1_r; blanked_s = b1_s; end
      2'd2: begin digit_s = d2_r; blanked_s = b2_s; end
      2'd3: begin digit_s = d3_r; blanked_s = b3_s; end
      default: begin digit_s = 4'd0; blanked_s = 1'b1; end
    endcase

    // Gating phase with the live blink input makes a blink release visible at once.
    dark_s = !en || (blink && phase_r) || blanked_s;

    if (dark_s) begin
      an_nxt_s  = 4'b1111;
      seg_nxt_s = 7'b1111111;
      dp_nxt_s  = 1'b1;
    end else begin
      an_nxt_s  = ~(4'b0001 << sel_r);
      seg_nxt_s = bcd_to_seg(digit_s);
      dp_nxt_s  = ~dp_en_r[sel_r];
    end
  end

  // Registered pin drive.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an_n  <= 4'b1111;
      seg_n <= 7'b1111111;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_nxt_s;
      seg_n <= seg_nxt_s;
      dp_n  <= dp_nxt_s;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Directed bench for sevenseg_scan_mux with REFRESH_DIV = 4 and BLINK_FRAMES = 2;
// expected segment/anode patterns are written out by hand for each slot.
module tb_sevenseg_scan_mux;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] d3, d2, d1, d0, dp_en;
  logic       blank_lz, blink, en;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sevenseg_scan_mux #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rstn(rstn),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .dp_en(dp_en), .blank_lz(blank_lz), .blink(blink), .en(en),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e);
    vectors++;
    assert ({an_n, seg_n, dp_n} === {an_e, seg_e, dp_e})
    else begin
      miscompares++;
      $error("FAIL %s: an_n/seg_n/dp_n observed %b/%b/%b expected %b/%b/%b",
             tag, an_n, seg_n, dp_n, an_e, seg_e, dp_e);
    end
  endtask

  task automatic slot(input string tag, input int n, input logic [3:0] an_e,
                      input logic [6:0] seg_e, input logic dp_e);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk(tag, an_e, seg_e, dp_e);
    end
  endtask

  task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
    slot(tag, 4, 4'b1110, s0, dpn[0]);
    slot(tag, 4, 4'b1101, s1, dpn[1]);
    slot(tag, 4, 4'b1011, s2, dpn[2]);
    slot(tag, 4, 4'b0111, s3, dpn[3]);
  endtask

  initial begin
    rstn = 1'b0;
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    dp_en = 4'b0010; blank_lz = 1'b0; blink = 1'b0; en = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b1111, OFF, 1'b1);
    rstn = 1'b1;

    // First slot still shows the all-zero shadow captured during reset.
    slot("init_slot", 1, 4'b1110, S0, 1'b1);
    slot("scan_d0", 3, 4'b1110, S4, 1'b1);
    slot("scan_d1", 4, 4'b1101, S3, 1'b0);
    slot("scan_d2", 4, 4'b1011, S2, 1'b1);
    slot("scan_d3", 4, 4'b0111, S1, 1'b1);

    slot("snap_d0", 4, 4'b1110, S4, 1'b1);
    slot("snap_d1", 1, 4'b1101, S3, 1'b0);
    d0 = 4'd7; d3 = 4'd9;
    slot("snap_d1b", 3, 4'b1101, S3, 1'b0);
    slot("snap_d2", 4, 4'b1011, S2, 1'b1);
    slot("snap_d3_old", 4, 4'b0111, S1, 1'b1);

    slot("snap_d0_new", 4, 4'b1110, S7, 1'b1);
    slot("snap_d1_same", 4, 4'b1101, S3, 1'b0);
    slot("pre_rst_d2", 2, 4'b1011, S2, 1'b1);

    #2 rstn = 1'b0;
    #1 chk("async_reset", 4'b1111, OFF, 1'b1);
    @(posedge clk);
    #1;
    chk("reset_hold", 4'b1111, OFF, 1'b1);
    rstn = 1'b1;

    slot("restart_init", 1, 4'b1110, S0, 1'b1);
    slot("restart_d0", 3, 4'b1110, S7, 1'b1);
    slot("restart_d1", 4, 4'b1101, S3, 1'b0);
    slot("restart_d2", 4, 4'b1011, S2, 1'b1);
    slot("restart_d3", 3, 4'b0111, S9, 1'b1);
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd5; d0 = 4'd0;
    dp_en = 4'b0000; blank_lz = 1'b1;
    slot("restart_d3_last", 1, 4'b0111, S9, 1'b1);

    slot("blank_d0", 4, 4'b1110, S0, 1'b1);
    slot("blank_d1", 4, 4'b1101, S5, 1'b1);
    slot("blank_d2", 4, 4'b1111, OFF, 1'b1);
    slot("blank_d3", 3, 4'b1111, OFF, 1'b1);
    dp_en = 4'b0100;
    slot("blank_d3_last", 1, 4'b1111, OFF, 1'b1);

    slot("blankdp_d0", 4, 4'b1110, S0, 1'b1);
    slot("blankdp_d1", 4, 4'b1101, S5, 1'b1);
    slot("blankdp_d2", 4, 4'b1011, S0, 1'b0);
    slot("blankdp_d3", 3, 4'b1111, OFF, 1'b1);
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'hB;
    dp_en = 4'b0000; blank_lz = 1'b0;
    slot("blankdp_d3_last", 1, 4'b1111, OFF, 1'b1);

    frame("invalid_bcd", DASH, S3, S2, S1, 4'b1111);

    blink = 1'b1;
    for (int f = 0; f < 2; f++) frame("blink_vis1", DASH, S3, S2, S1, 4'b1111);
    slot("blink_dark1", 32, 4'b1111, OFF, 1'b1);
    for (int f = 0; f < 2; f++) frame("blink_vis2", DASH, S3, S2, S1, 4'b1111);
    slot("blink_dark2", 1, 4'b1111, OFF, 1'b1);
    blink = 1'b0;
    slot("blink_release", 3, 4'b1110, DASH, 1'b1);
    slot("post_blink_d1", 4, 4'b1101, S3, 1'b1);

    en = 1'b0;
    slot("en_off", 4, 4'b1111, OFF, 1'b1);
    en = 1'b1;
    slot("en_on_d3", 4, 4'b0111, S1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_mux.md
Name: sevenseg_scan_mux

Overview:
- Drives a 4-digit, common-anode, multiplexed 7-segment display from four BCD digits d3..d0, as produced by the stopwatch counter (d3 = MSD).
- Scans one digit per refresh slot and snapshots its inputs once per frame, so the display never tears.
- Adds decimal points, leading-zero blanking, whole-display blink and enable.
- Sits between the stopwatch digit outputs and the board segment/anode pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (≥2); one frame = 4*REFRESH_DIV cycles.
- BLINK_FRAMES, 64, frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- d3, d2, d1, d0  in  4 each  BCD digits; d0 is the rightmost digit.
- dp_en  in  4  decimal-point enable per digit; bit i maps to digit i.
- blank_lz  in  1  leading-zero blanking enable.
- blink  in  1  1 = whole display blinks.
- en  in  1  0 = all digits dark.
- an_n  out  4  anode drive, active-low; bit i = digit i.
- seg_n  out  7  segments, active-low, order gfedcba (bit0 = a, bit6 = g).
- dp_n  out  1  decimal point, active-low.

Behaviour:
- Reset (rstn low, asynchronous, including mid-scan):
  - Counters, sel, shadow registers, blink state and init flag = 0.
  - an_n = 4'b1111, seg_n = 7'b1111111, dp_n = 1.
- Prescaler:
  - tick_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (tick_cnt == REFRESH_DIV-1).
- Digit select:
  - sel (2 bits) increments on tick and wraps 3 -> 0.
  - frame_end = tick && sel == 3.
- Snapshot:
  - d3..d0, dp_en and blank_lz are latched into shadow registers on frame_end.
  - They are also latched on the first clock after reset release (init flag); the init flag is then set.
  - All display logic uses shadow values only.
  - An input change becomes visible only after the next frame_end.
- Decode (shadow digit at sel):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001,
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Values 10..15 display dash = 0111111.
- Leading-zero blanking (shadow blank_lz = 1):
  - b3 = (d3 == 0) && !dp_en[3].
  - b2 = b3 && (d2 == 0) && !dp_en[2].
  - b1 = b2 && (d1 == 0) && !dp_en[1].
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode high, seg_n = 1111111 and dp_n = 1.
- Decimal point: dp_n = ~dp_en[sel] for an active, non-blanked digit.
- Blink:
  - While blink = 0: frame counter and phase are held at 0.
  - While blink = 1: the frame counter counts frame_end events; when it reaches BLINK_FRAMES-1 with another frame_end, it wraps to 0 and phase toggles.
  - phase = 1 turns all anodes off.
  - The blink input is live (not shadowed).
- Enable: en = 0 turns all anodes off; prescaler, sel, snapshot and blink keep running.
- Output register:
  - an_n, seg_n and dp_n are registered, one cycle after sel/shadow/phase/en change.
  - When dark (en = 0, phase = 1, or blanked digit): an_n = 1111, seg_n = 1111111, dp_n = 1.
  - Otherwise an_n has only bit sel low.
- Exactly one anode is low at any time when the display is visible; never more than one.

Test Plan (REFRESH_DIV = 4, BLINK_FRAMES = 2):
1. Reset: rstn low mid-scan with digit 2 lit -> an_n = 1111, seg_n = 1111111, dp_n = 1 immediately, without waiting for clk; after release, scan restarts at digit 0.
2. d3..d0 = 1,2,3,4, dp_en = 0010, blank_lz = 0, en = 1 -> an_n cycles 1110/1101/1011/0111, each held 4 cycles.
   - seg_n follows 0011001 / 0110000 / 0100100 / 1111001.
   - dp_n = 0 only while an_n = 1101.
3. Snapshot: change d0 4 -> 7 while digit 1 is lit -> digit 0 still shows 0011001 for the rest of the frame, then 1111000 after frame_end.
4. Blanking: d = 0,0,5,0, blank_lz = 1, dp_en = 0000 -> anodes 3 and 2 never low; digit 1 = 0010010, digit 0 = 1000000.
   - Then dp_en = 0100 -> digit 2 shows 1000000 with dp_n = 0; digit 3 stays blank.
5. Invalid BCD: d0 = 4'hB -> seg_n = 0111111 in digit-0 slot; other digits unaffected.
6. Blink/enable: blink = 1 asserted at a frame boundary -> visible 32 cycles, dark 32 cycles, repeating.
   - blink = 0 while dark -> visible the next cycle.
   - en = 0 -> an_n = 1111 the next cycle; sel keeps advancing.
